uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, next generation of the fixed 8N1 transmitter. Supports configurable data width, optional odd/even parity and 1 or 2 stop bits. A one-entry holding register behind a valid/ready handshake lets frames go out back-to-back with no idle gap. Sits between the byte source (FIFO or register bank) and the tx pin, and is paced by the shared baud-tick generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
tick  in  1  one-clk pulse per bit period, from the baud generator.
s_valid  in  1  source has a word on s_data.
s_data  in  DATA_BITS  word to send; LSB is transmitted first.
s_ready  out  1  holding register empty; a transfer occurs when s_valid && s_ready.
tx  out  1  serial line; idles high.
busy  out  1  high while a frame is in flight or the holding register is full.
brk  in  1  line-break request; present only with UART_TX_BREAK_EN.

Behaviour:
- Reset (async, rst_n low): tx=1, busy=0, s_ready=1, holding register empty, state=IDLE, bit counter=0. Reset mid-frame aborts the frame immediately and leaves tx high.
- Handshake: on a transfer, s_data is captured into the holding register and s_ready drops on the next edge. s_ready stays high when s_valid is low.
- State machine: IDLE, START, DATA, PAR, STOP. All transitions, and all tx changes, happen only on clk edges where tick=1. tx is registered.
- IDLE: tx=1. On a tick with holding full: move holding into the shift register, free holding (s_ready=1 next cycle), enter START and drive tx=0.
- A word accepted in the same cycle as an IDLE tick waits for the next tick. There is no bypass.
- START: on tick, enter DATA and drive tx=data[0].
- DATA: on each tick, advance the counter and drive the next bit. After bit DATA_BITS-1 completes, go to PAR if PARITY!=0, else STOP.
- PAR: tx = XOR of the data bits for even parity; inverted for odd.
- STOP: tx=1 for STOP_BITS tick periods. On the tick ending the last stop bit:
  - if holding is full, go straight to START (tx=0) with no idle cycle;
  - otherwise go to IDLE.
- Timing: every bit is held for exactly one tick interval. Frame length is 1 + DATA_BITS + (PARITY!=0) + STOP_BITS ticks.
- busy = (state!=IDLE) || holding full. It is registered and updated on the same edges as state and holding.
- A word can be accepted while a frame is in flight; the holding register is freed at the START load.
- Counter width is $clog2(DATA_BITS). The counter clears on entry to START.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: the brk port exists.
- If brk=1 at an IDLE tick, enter BRK: tx=0, s_ready=0, busy=1. The state stays BRK while brk=1.
- Exit to IDLE happens on the first tick with brk=0. tx=1 is then held for at least one full tick interval (mark-after-break) before any START.
- A break is never inserted mid-frame.
- Undefined: there is no brk port and no BRK state.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PAR, STOP, BRK);
  - the PARITY encodings PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - parameter-range checks.
- One natural sub-module: uart_tx_hold, a one-entry valid/ready holding register with capture and release. It is reusable for the future RX output skid.

Test Plan:
1. DATA_BITS=8, PARITY=0, STOP=1; send 0xA5 -> tx per tick reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); busy lasts 10 ticks plus the load tick.
2. Send 0x55 then 0x0F, with the second s_valid asserted during 0x55's data bits -> the second start bit begins on the tick ending 0x55's stop bit; no idle tick; s_ready re-rises at 0x0F's load.
3. PARITY=2 with 0x07 -> parity bit 1; PARITY=1 with 0x07 -> parity bit 0; frames are 11 ticks.
4. STOP_BITS=2, DATA_BITS=5, send 0x1F -> 0,1,1,1,1,1,1,1 then idle; line high for 2 full tick periods before the next start.
5. Assert rst_n=0 during data bit 3 of 0xF0 -> tx=1, busy=0, s_ready=1 asynchronously; the next send produces a clean frame.
6. (UART_TX_BREAK_EN) Hold brk for 15 ticks while IDLE -> tx low for 15 tick periods, s_ready=0 throughout; then at least 1 tick of mark before a pending 0x3C starts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: transmitter state encoding, parity encodings and
// parameter legality check. The BRK state exists only with UART_TX_BREAK_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
`ifdef UART_TX_BREAK_EN
        ST_STOP,
        ST_BRK
`else
        ST_STOP
`endif
    } uart_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // True when the frame format is one the transmitter supports.
    function automatic bit uart_cfg_ok(input int unsigned data_bits,
                                       input int unsigned parity,
                                       input int unsigned stop_bits);
        return (data_bits >= 32'd5) && (data_bits <= 32'd9) &&
               (parity <= PAR_EVEN) &&
               ((stop_bits == 32'd1) || (stop_bits == 32'd2));
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry valid/ready holding register. Captures on in_valid && in_ready,
// releases on take. block_nxt keeps in_ready low for the coming cycle.
module uart_tx_hold #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         block_nxt,
    input  logic         take,
    output logic         full,
    output logic         full_nxt_c,
    output logic [W-1:0] out_data
);

    logic accept_c;

    // Occupancy after this edge: a take empties, an accept fills.
    always_comb begin
        accept_c   = in_valid && in_ready;
        full_nxt_c = (full && !take) || accept_c;
    end

    // Occupancy, ready flag and captured word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            in_ready <= 1'b1;
            out_data <= '0;
        end else begin
            full     <= full_nxt_c;
            in_ready <= !full_nxt_c && !block_nxt;
            if (accept_c) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity,
// 1 or 2 stop bits, back-to-back frames from a one-entry holding register.
// Optional line break: define UART_TX_BREAK_EN to add the brk port.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 s_valid,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 s_ready,
    output logic                 tx,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS);

    // Reject unsupported frame formats at elaboration.
    generate
        if (!uart_cfg_ok(DATA_BITS, PARITY, STOP_BITS)) begin : g_cfg_err
            $error("uart_tx_frame: unsupported DATA_BITS/PARITY/STOP_BITS");
        end
    endgenerate

    uart_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 tx_d;
    logic                 busy_d;
    logic                 load_c;
    logic                 block_nxt_c;
    logic                 hold_full;
    logic                 hold_full_nxt;
    logic [DATA_BITS-1:0] hold_data;

    uart_tx_hold #(.W(DATA_BITS)) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s_valid),
        .in_data    (s_data),
        .in_ready   (s_ready),
        .block_nxt  (block_nxt_c),
        .take       (load_c),
        .full       (hold_full),
        .full_nxt_c (hold_full_nxt),
        .out_data   (hold_data)
    );

    // Next state, line level and datapath; everything moves only on tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = tx;
        load_c  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                    if (brk) begin
                        state_d = ST_BRK;
                        tx_d    = 1'b0;
                    end else
`endif
                    if (hold_full) begin
                        load_c = 1'b1;
                    end
                end
                ST_START: begin
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        cnt_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
                ST_PAR: begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
                ST_STOP: begin
                    if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
                        if (hold_full) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_BREAK_EN
                ST_BRK: begin
                    if (!brk) begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
            // Frame load from the holding register: start bit goes out now.
            if (load_c) begin
                state_d = ST_START;
                tx_d    = 1'b0;
                cnt_d   = '0;
                sh_d    = hold_data;
                par_d   = (^hold_data) ^ (PARITY == PAR_ODD);
            end
        end
`ifdef UART_TX_BREAK_EN
        block_nxt_c = (state_d == ST_BRK);
`else
        block_nxt_c = 1'b0;
`endif
        busy_d = (state_d != ST_IDLE) || hold_full_nxt;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations side by side (8N1, 8E1, 8O1,
// 5N2), a frame scoreboard per instance fed at each accepted transfer, and
// hand sequences for busy timing, back-to-back frames, reset and break.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] sv;
    logic [7:0] sd [4];
    logic [3:0] txw, busyw, rdyw;
`ifdef UART_TX_BREAK_EN
    logic       brk0;
`endif

    typedef struct {
        logic [11:0] bits;   // bit i = i-th serial bit on the line
        int          len;
    } frame_t;

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [11:0] bits;
        int          len;
    } vec_t;

    frame_t exp_q [4][$];
    vec_t   vec [11];

    int     checks = 0;
    int     failures = 0;
    int     tick_no = 0;
    bit     mon_en = 1'b0;
    bit     brk_on = 1'b0;
    bit     in_frame [4];
    int     pos [4];
    frame_t cur [4];
    int     nstarts [4];
    int     last_start [4];

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .s_valid(sv[0]), .s_data(sd[0]),
        .s_ready(rdyw[0]), .tx(txw[0]),
`ifdef UART_TX_BREAK_EN
        .brk(brk0),
`endif
        .busy(busyw[0]));

    uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e81 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .s_valid(sv[1]), .s_data(sd[1]),
        .s_ready(rdyw[1]), .tx(txw[1]),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .busy(busyw[1]));

    uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o81 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .s_valid(sv[2]), .s_data(sd[2]),
        .s_ready(rdyw[2]), .tx(txw[2]),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .busy(busyw[2]));

    uart_tx_frame #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_n52 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .s_valid(sv[3]), .s_data(sd[3][4:0]),
        .s_ready(rdyw[3]), .tx(txw[3]),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .busy(busyw[3]));

    // Baud tick: one clk pulse every four clocks.
    initial begin
        int c = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (c == 3);
            c = (c + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Line monitor: a falling line on an idle instance opens the next expected
    // frame; each following tick compares one serial bit.
    initial begin
        forever begin
            @(posedge clk);
            if (tick) begin
                #1;
                tick_no++;
                if (mon_en) begin
                    for (int i = 0; i < 4; i++) begin
                        if (!(i == 0 && brk_on)) begin
                            if (!in_frame[i] && txw[i] == 1'b0) begin
                                if (exp_q[i].size() == 0) begin
                                    check($sformatf("unexpected_start_i%0d", i), 32'(txw[i]), 32'd1);
                                end else begin
                                    cur[i] = exp_q[i].pop_front();
                                    in_frame[i] = 1'b1;
                                    pos[i] = 0;
                                    nstarts[i]++;
                                    last_start[i] = tick_no;
                                end
                            end
                            if (in_frame[i]) begin
                                check($sformatf("frame_bit_i%0d_p%0d", i, pos[i]),
                                      32'(txw[i]), 32'(cur[i].bits[pos[i]]));
                                pos[i]++;
                                if (pos[i] == cur[i].len) in_frame[i] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Returns just after the monitor has processed the next tick edge.
    task automatic wait_tick();
        do @(posedge clk); while (!tick);
        #2;
    endtask

    // Offer a word, wait for the transfer, then queue its expected frame.
    task automatic send(input int i, input logic [7:0] d, input logic [11:0] bits, input int len);
        int n = 0;
        frame_t f;
        @(negedge clk);
        sv[i] = 1'b1;
        sd[i] = d;
        while (!rdyw[i] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!rdyw[i]) begin
            check($sformatf("send_ready_i%0d", i), 32'(rdyw[i]), 32'd1);
            sv[i] = 1'b0;
            return;
        end
        @(posedge clk);
        f.bits = bits;
        f.len  = len;
        exp_q[i].push_back(f);
        #1;
        sv[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((exp_q[i].size() != 0 || in_frame[i] || busyw[i]) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_reached_i%0d", i), 32'(n < 1000), 32'd1);
    endtask

    task automatic wait_start(input int i, output int t);
        int n0 = nstarts[i];
        int k = 0;
        while (nstarts[i] == n0 && k < 40) begin
            wait_tick();
            k++;
        end
        check($sformatf("start_seen_i%0d", i), 32'(nstarts[i] != n0), 32'd1);
        t = last_start[i];
    endtask

    initial begin
        int t0, t1;
        rst_n = 1'b0;
        sv = '0;
        for (int i = 0; i < 4; i++) sd[i] = '0;
`ifdef UART_TX_BREAK_EN
        brk0 = 1'b0;
`endif
        // {instance, word, expected serial bits (bit0 first), frame length}
        vec[0]  = '{0, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}), 10};
        vec[1]  = '{0, 8'h00, 12'({1'b1, 8'h00, 1'b0}), 10};
        vec[2]  = '{0, 8'hFF, 12'({1'b1, 8'hFF, 1'b0}), 10};
        vec[3]  = '{1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11};
        vec[4]  = '{1, 8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, 11};
        vec[5]  = '{1, 8'h80, {1'b1, 1'b1, 8'h80, 1'b0}, 11};
        vec[6]  = '{2, 8'h07, {1'b1, 1'b0, 8'h07, 1'b0}, 11};
        vec[7]  = '{2, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 11};
        vec[8]  = '{2, 8'h03, {1'b1, 1'b1, 8'h03, 1'b0}, 11};
        vec[9]  = '{3, 8'h1F, 12'({2'b11, 5'h1F, 1'b0}), 8};
        vec[10] = '{3, 8'h0A, 12'({2'b11, 5'h0A, 1'b0}), 8};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_tx_i%0d", i), 32'(txw[i]), 32'd1);
            check($sformatf("reset_busy_i%0d", i), 32'(busyw[i]), 32'd0);
            check($sformatf("reset_ready_i%0d", i), 32'(rdyw[i]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Table of single frames across all four formats.
        for (int v = 0; v < 11; v++) begin
            send(vec[v].inst, vec[v].data, vec[v].bits, vec[v].len);
            wait_idle(vec[v].inst);
        end

        // Busy spans the load wait plus exactly ten tick periods.
        send(0, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}), 10);
        check("busy_after_accept", 32'(busyw[0]), 32'd1);
        check("ready_after_accept", 32'(rdyw[0]), 32'd0);
        wait_start(0, t0);
        check("ready_at_load", 32'(rdyw[0]), 32'd1);
        repeat (9) wait_tick();
        check("busy_in_stop", 32'(busyw[0]), 32'd1);
        wait_tick();
        check("busy_after_frame", 32'(busyw[0]), 32'd0);
        check("tx_idle_after_frame", 32'(txw[0]), 32'd1);
        wait_idle(0);

        // Back-to-back: second word accepted mid-frame, no idle tick between.
        send(0, 8'h55, 12'({1'b1, 8'h55, 1'b0}), 10);
        wait_start(0, t0);
        repeat (3) wait_tick();
        send(0, 8'h0F, 12'({1'b1, 8'h0F, 1'b0}), 10);
        check("b2b_ready_held_low", 32'(rdyw[0]), 32'd0);
        check("b2b_busy", 32'(busyw[0]), 32'd1);
        wait_start(0, t1);
        check("b2b_start_gap", 32'(t1 - t0), 32'd10);
        check("b2b_ready_at_load", 32'(rdyw[0]), 32'd1);
        wait_idle(0);

        // Two stop bits: next start follows a full 8-tick frame.
        send(3, 8'h1F, 12'({2'b11, 5'h1F, 1'b0}), 8);
        wait_start(3, t0);
        send(3, 8'h0A, 12'({2'b11, 5'h0A, 1'b0}), 8);
        wait_start(3, t1);
        check("stop2_start_gap", 32'(t1 - t0), 32'd8);
        wait_idle(3);

        // Reset during data bit 3 of 0xF0 (a low bit), then a clean frame.
        send(0, 8'hF0, 12'({1'b1, 8'hF0, 1'b0}), 10);
        wait_start(0, t0);
        repeat (4) wait_tick();
        check("pre_reset_tx_low", 32'(txw[0]), 32'd0);
        #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_tx", 32'(txw[0]), 32'd1);
        check("midreset_busy", 32'(busyw[0]), 32'd0);
        check("midreset_ready", 32'(rdyw[0]), 32'd1);
        exp_q[0].delete();
        in_frame[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        send(0, 8'h3C, 12'({1'b1, 8'h3C, 1'b0}), 10);
        wait_idle(0);

`ifdef UART_TX_BREAK_EN
        // Break held for 15 ticks, then mark before the pending word.
        brk_on = 1'b1;
        @(negedge clk);
        brk0 = 1'b1;
        wait_tick();
        check("brk_entry_tx", 32'(txw[0]), 32'd0);
        check("brk_entry_ready", 32'(rdyw[0]), 32'd0);
        check("brk_entry_busy", 32'(busyw[0]), 32'd1);
        for (int k = 1; k < 15; k++) begin
            if (k == 7) begin
                sv[0] = 1'b1;
                sd[0] = 8'h3C;
            end
            wait_tick();
            check($sformatf("brk_low_k%0d", k), 32'(txw[0]), 32'd0);
            check($sformatf("brk_ready_k%0d", k), 32'(rdyw[0]), 32'd0);
        end
        @(negedge clk);
        brk0 = 1'b0;
        wait_tick();
        t0 = tick_no;
        check("brk_exit_mark", 32'(txw[0]), 32'd1);
        brk_on = 1'b0;
        send(0, 8'h3C, 12'({1'b1, 8'h3C, 1'b0}), 10);
        wait_start(0, t1);
        check("brk_mark_ticks", 32'(t1 - t0 >= 1), 32'd1);
        wait_idle(0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
